// File: rtl/sonic_pkg.sv
// Shared definitions for the ultrasonic ranging controller and its echo emulator:
// FSM state encoding and the speed-of-sound constants both sides must agree on.
package sonic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG_HI,
        ST_BURST,
        ST_ECHO,
        ST_HOLDOFF
    } sonic_state_t;

    localparam int SONIC_CM_PER_S = 34000;
    // Round trip of 2 cm takes 2e6/34000 = 58.8 us; the sensor convention truncates to 58.
    localparam int SONIC_US_PER_CM = 2_000_000 / SONIC_CM_PER_S;
    localparam int SONIC_MAX_CM = 400;
    localparam int SONIC_TIMEOUT_US = 38000;

endpackage

// File: rtl/sonic_us_tick.sv
// Microsecond prescaler: one-cycle tick every CLK_PER_US clocks, restartable with clr.
// The clr cycle is counted as the first clock of the new microsecond.
module sonic_us_tick #(
    parameter int CLK_PER_US = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_US - 1);
    localparam logic [CW-1:0] FIRST = (CLK_PER_US > 1) ? CW'(1) : '0;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= FIRST;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST) && (!clr || (CLK_PER_US == 1));

endmodule

// File: rtl/sonic_echo_emulator.sv
// Ultrasonic sensor responder: qualifies trig, waits the burst delay, then drives an echo
// whose width encodes distance_cm. Define SONIC_EMU_JITTER_EN to add 0..3 us LFSR jitter.
module sonic_echo_emulator
    import sonic_pkg::*;
#(
    parameter int CLK_PER_US  = 100,
    parameter int TRIG_MIN_US = 10,
    parameter int BURST_US    = 200,
    parameter int US_PER_CM   = SONIC_US_PER_CM,
    parameter int MAX_CM      = SONIC_MAX_CM,
    parameter int TIMEOUT_US  = SONIC_TIMEOUT_US,
    parameter int HOLDOFF_US  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [8:0] distance_cm,
    output logic       echo,
    output logic       busy,
    output logic       done
);

    localparam int TRIG_MIN_CYC = TRIG_MIN_US * CLK_PER_US;
    localparam int WCW = $clog2(TRIG_MIN_CYC + 1);
    localparam logic [WCW-1:0] TRIG_MIN_W = WCW'(TRIG_MIN_CYC);

    logic         trig_m, trig_s, trig_q;
    logic         trig_rise, trig_fall;
    sonic_state_t state;
    logic [WCW-1:0] width_cnt;
    logic [15:0]  us_cnt;
    logic [8:0]   latched_cm;
    logic [15:0]  echo_us;
    logic         tick_clr, tick;
    logic         trig_ok;

    // Out-of-range and zero distances report the no-object timeout width.
    function automatic logic [15:0] echo_width_us(input logic [8:0] cm);
        logic [15:0] cm16;
        cm16 = {7'd0, cm};
        if (cm16 == 16'd0 || cm16 > 16'(MAX_CM))
            return 16'(TIMEOUT_US);
        return cm16 * 16'(US_PER_CM);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_m <= 1'b0;
            trig_s <= 1'b0;
            trig_q <= 1'b0;
        end else begin
            trig_m <= trig;
            trig_s <= trig_m;
            trig_q <= trig_s;
        end
    end

    assign trig_rise = trig_s & ~trig_q;
    assign trig_fall = ~trig_s & trig_q;
    assign trig_ok   = (state == ST_TRIG_HI) && trig_fall && (width_cnt >= TRIG_MIN_W);

`ifdef SONIC_EMU_JITTER_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 8'hA5;
        else if (trig_ok)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign echo_us = echo_width_us(latched_cm) + 16'(lfsr[1:0]);
`else
    assign echo_us = echo_width_us(latched_cm);
`endif

    sonic_us_tick #(
        .CLK_PER_US(CLK_PER_US)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            width_cnt  <= '0;
            us_cnt     <= '0;
            latched_cm <= '0;
            echo       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tick_clr   <= 1'b0;
        end else begin
            done     <= 1'b0;
            tick_clr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // The rise cycle itself is the first high cycle of the trigger.
                    if (trig_rise) begin
                        state     <= ST_TRIG_HI;
                        width_cnt <= WCW'(1);
                    end else begin
                        width_cnt <= '0;
                    end
                end
                ST_TRIG_HI: begin
                    if (trig_ok) begin
                        latched_cm <= distance_cm;
                        us_cnt     <= '0;
                        tick_clr   <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_BURST;
                    end else if (trig_fall) begin
                        state <= ST_IDLE;
                    end else if (trig_s && width_cnt != TRIG_MIN_W) begin
                        width_cnt <= width_cnt + 1'b1;
                    end
                end
                ST_BURST: begin
                    if (tick) begin
                        if (us_cnt == 16'(BURST_US - 1)) begin
                            us_cnt   <= '0;
                            tick_clr <= 1'b1;
                            echo     <= 1'b1;
                            state    <= ST_ECHO;
                        end else begin
                            us_cnt <= us_cnt + 1'b1;
                        end
                    end
                end
                ST_ECHO: begin
                    if (tick) begin
                        if (us_cnt == echo_us - 16'd1) begin
                            us_cnt   <= '0;
                            tick_clr <= 1'b1;
                            echo     <= 1'b0;
                            done     <= 1'b1;
                            state    <= ST_HOLDOFF;
                        end else begin
                            us_cnt <= us_cnt + 1'b1;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (tick) begin
                        if (us_cnt == 16'(HOLDOFF_US - 1)) begin
                            us_cnt    <= '0;
                            width_cnt <= '0;
                            busy      <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            us_cnt <= us_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    echo  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sonic_echo_emulator.sv
// Directed bench for sonic_echo_emulator with a scaled timebase: 4 clk/us, 3 us/cm,
// 10 us trigger minimum (40 clk), 20 us burst, 1500 us timeout, 50 us holdoff.
module tb_sonic_echo_emulator;

    localparam int CPU = 4;
    localparam int TMIN = 10;
    localparam int BURST = 20;
    localparam int UPC = 3;
    localparam int MAXCM = 400;
    localparam int TMO = 1500;
    localparam int HOLD = 50;

    // Trig is sampled high on N edges then dropped; the first low edge is step 1, two sync
    // flops and the edge-detect cycle put BURST entry at step 3, echo rise 80 clk later.
    localparam int EXP_DELAY = 83;
    localparam int EXP_HOLD = 200;      // 50 us * 4
    localparam int W100 = 1200;         // 100 cm * 3 us * 4
    localparam int W20 = 240;           // 20 cm * 3 * 4
    localparam int W400 = 4800;         // 400 cm * 3 * 4
    localparam int W1 = 12;             // 1 cm * 3 * 4
    localparam int WTMO = 6000;         // 1500 us * 4
    localparam int BOUND = 20000;

    logic       clk = 1'b0;
    logic       rst;
    logic       trig;
    logic [8:0] distance_cm;
    logic       echo, busy, done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sonic_echo_emulator #(
        .CLK_PER_US (CPU),
        .TRIG_MIN_US(TMIN),
        .BURST_US   (BURST),
        .US_PER_CM  (UPC),
        .MAX_CM     (MAXCM),
        .TIMEOUT_US (TMO),
        .HOLDOFF_US (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trig       (trig),
        .distance_cm(distance_cm),
        .echo       (echo),
        .busy       (busy),
        .done       (done)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One full measurement; returns observed timings, optional disturbances injected.
    task automatic measure(input int trig_len, input int chg_at, input logic [8:0] chg_val,
                           input int echo_rt, input int hold_rt,
                           output int dly, output int width, output int dones, output int hold,
                           output logic busy_in_echo, output logic fall_done, output logic timed_out);
        int n;
        dly = 0; width = 0; dones = 0; hold = 0;
        busy_in_echo = 1'b1; fall_done = 1'b0; timed_out = 1'b0;
        trig = 1'b1;
        for (int i = 0; i < trig_len; i++) step();
        trig = 1'b0;
        n = 0;
        while (echo !== 1'b1 && n < BOUND) begin
            step();
            n++;
            if (n == chg_at) distance_cm = chg_val;
            if (done === 1'b1) dones++;
        end
        dly = n;
        if (n >= BOUND) timed_out = 1'b1;
        n = 0;
        while (echo === 1'b1 && n < BOUND) begin
            if (busy !== 1'b1) busy_in_echo = 1'b0;
            if (done === 1'b1) dones++;
            if (echo_rt >= 0 && n == echo_rt) trig = 1'b1;
            if (echo_rt >= 0 && n == echo_rt + 40) trig = 1'b0;
            step();
            n++;
        end
        width = n;
        if (n >= BOUND) timed_out = 1'b1;
        fall_done = (done === 1'b1);
        if (done === 1'b1) dones++;
        n = 0;
        while (busy === 1'b1 && n < BOUND) begin
            if (hold_rt >= 0 && n == hold_rt) trig = 1'b1;
            if (hold_rt >= 0 && n == hold_rt + 40) trig = 1'b0;
            step();
            n++;
            if (done === 1'b1) dones++;
        end
        hold = n;
        if (n >= BOUND) timed_out = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; trig = 1'b0; distance_cm = 9'd0;
        repeat (3) step();
        vectors++;
        if ({echo, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_outputs: echo/busy/done=%b%b%b, required 000", echo, busy, done);
        end
        rst = 1'b0;
        step();
        vectors++;
        if ({echo, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_release: echo/busy/done=%b%b%b, required 000", echo, busy, done);
        end
    endtask

    task automatic test_nominal;
        int d, w, dn, h; logic bie, fd, to;
        distance_cm = 9'd100;
        measure(40, -1, 9'd0, -1, -1, d, w, dn, h, bie, fd, to);
        vectors++;
        if (to !== 1'b0) begin miscompares++; $display("FAIL nominal_timeout: got %b, required 0", to); end
        vectors++;
        if (d != EXP_DELAY) begin miscompares++; $display("FAIL nominal_delay: got %0d, required %0d", d, EXP_DELAY); end
        vectors++;
        if (w != W100) begin miscompares++; $display("FAIL nominal_width: got %0d, required %0d", w, W100); end
        vectors++;
        if (bie !== 1'b1) begin miscompares++; $display("FAIL nominal_busy_echo: got %b, required 1", bie); end
        vectors++;
        if (fd !== 1'b1 || dn != 1) begin
            miscompares++;
            $display("FAIL nominal_done: at_fall=%b count=%0d, required 1 and 1", fd, dn);
        end
        vectors++;
        if (h != EXP_HOLD) begin miscompares++; $display("FAIL nominal_holdoff: got %0d, required %0d", h, EXP_HOLD); end
    endtask

    task automatic test_short_trigger;
        int d, w, dn, h; logic bie, fd, to; logic seen_echo, seen_busy;
        distance_cm = 9'd100;
        trig = 1'b1;
        repeat (39) step();
        trig = 1'b0;
        seen_echo = 1'b0; seen_busy = 1'b0;
        repeat (300) begin
            step();
            if (echo === 1'b1) seen_echo = 1'b1;
            if (busy === 1'b1) seen_busy = 1'b1;
        end
        vectors++;
        if (seen_echo !== 1'b0 || seen_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL short_trig_ignored: echo_seen=%b busy_seen=%b, required 0 0", seen_echo, seen_busy);
        end
        measure(40, -1, 9'd0, -1, -1, d, w, dn, h, bie, fd, to);
        vectors++;
        if (d != EXP_DELAY || w != W100) begin
            miscompares++;
            $display("FAIL min_trig_accepted: delay=%0d width=%0d, required %0d %0d", d, w, EXP_DELAY, W100);
        end
    endtask

    task automatic test_range_limits;
        int d, w, dn, h; logic bie, fd, to;
        distance_cm = 9'd450;
        measure(40, -1, 9'd0, -1, -1, d, w, dn, h, bie, fd, to);
        vectors++;
        if (w != WTMO) begin miscompares++; $display("FAIL range_450: got %0d, required %0d", w, WTMO); end
        distance_cm = 9'd0;
        measure(40, -1, 9'd0, -1, -1, d, w, dn, h, bie, fd, to);
        vectors++;
        if (w != WTMO) begin miscompares++; $display("FAIL range_0: got %0d, required %0d", w, WTMO); end
        distance_cm = 9'd400;
        measure(40, -1, 9'd0, -1, -1, d, w, dn, h, bie, fd, to);
        vectors++;
        if (w != W400) begin miscompares++; $display("FAIL range_400: got %0d, required %0d", w, W400); end
        distance_cm = 9'd1;
        measure(40, -1, 9'd0, -1, -1, d, w, dn, h, bie, fd, to);
        vectors++;
        if (w != W1) begin miscompares++; $display("FAIL range_1: got %0d, required %0d", w, W1); end
    endtask

    task automatic test_retrigger;
        int d, w, dn, h; logic bie, fd, to; logic seen_echo, seen_busy;
        distance_cm = 9'd100;
        measure(40, -1, 9'd0, 200, 20, d, w, dn, h, bie, fd, to);
        vectors++;
        if (w != W100 || h != EXP_HOLD || dn != 1) begin
            miscompares++;
            $display("FAIL retrig_ignored: width=%0d hold=%0d dones=%0d, required %0d %0d 1", w, h, dn, W100, EXP_HOLD);
        end
        measure(40, -1, 9'd0, -1, -1, d, w, dn, h, bie, fd, to);
        vectors++;
        if (d != EXP_DELAY || w != W100) begin
            miscompares++;
            $display("FAIL retrig_next: delay=%0d width=%0d, required %0d %0d", d, w, EXP_DELAY, W100);
        end
        // Trigger raised late in holdoff stays high across the return to idle.
        measure(40, -1, 9'd0, -1, 180, d, w, dn, h, bie, fd, to);
        repeat (20) step();
        trig = 1'b0;
        seen_echo = 1'b0; seen_busy = 1'b0;
        repeat (300) begin
            step();
            if (echo === 1'b1) seen_echo = 1'b1;
            if (busy === 1'b1) seen_busy = 1'b1;
        end
        vectors++;
        if (seen_echo !== 1'b0 || seen_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL trig_into_idle: echo_seen=%b busy_seen=%b, required 0 0", seen_echo, seen_busy);
        end
    endtask

    task automatic test_reset_mid_echo;
        int n, d, w, dn, h; logic bie, fd, to; logic seen_echo, seen_done;
        distance_cm = 9'd100;
        trig = 1'b1;
        repeat (40) step();
        trig = 1'b0;
        n = 0;
        while (echo !== 1'b1 && n < 1000) begin step(); n++; end
        vectors++;
        if (echo !== 1'b1) begin miscompares++; $display("FAIL rst_echo_start: echo=%b, required 1", echo); end
        repeat (600) step();
        rst = 1'b1;
        step();
        vectors++;
        if ({echo, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_abort: echo/busy/done=%b%b%b, required 000", echo, busy, done);
        end
        rst = 1'b0;
        seen_echo = 1'b0; seen_done = 1'b0;
        repeat (300) begin
            step();
            if (echo === 1'b1) seen_echo = 1'b1;
            if (done === 1'b1) seen_done = 1'b1;
        end
        vectors++;
        if (seen_echo !== 1'b0 || seen_done !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_quiet: echo_seen=%b done_seen=%b, required 0 0", seen_echo, seen_done);
        end
        measure(40, -1, 9'd0, -1, -1, d, w, dn, h, bie, fd, to);
        vectors++;
        if (d != EXP_DELAY || w != W100 || dn != 1) begin
            miscompares++;
            $display("FAIL rst_recover: delay=%0d width=%0d dones=%0d, required %0d %0d 1", d, w, dn, EXP_DELAY, W100);
        end
    endtask

    task automatic test_distance_change;
        int d, w, dn, h; logic bie, fd, to;
        distance_cm = 9'd100;
        measure(40, 20, 9'd20, -1, -1, d, w, dn, h, bie, fd, to);
        vectors++;
        if (w != W100) begin miscompares++; $display("FAIL dist_latched: got %0d, required %0d", w, W100); end
        measure(40, -1, 9'd0, -1, -1, d, w, dn, h, bie, fd, to);
        vectors++;
        if (w != W20) begin miscompares++; $display("FAIL dist_next: got %0d, required %0d", w, W20); end
    endtask

    initial begin
        rst = 1'b1;
        trig = 1'b0;
        distance_cm = 9'd0;
        test_reset();
        test_nominal();
        test_short_trigger();
        test_range_limits();
        test_retrigger();
        test_reset_mid_echo();
        test_distance_change();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
